iodec_gen: RTL and testbench
============================

Name: iodec_gen

Overview:
- Parametrised, registered successor to the fixed TOM I/O register decoder.
- Decodes a halfword-aligned register window into one-hot read and write strobes, and inserts a programmable number of wait states before acknowledging.
- Signals accesses that fall outside the window to external expansion, and keeps a sticky error flag.
- Sits between the internal bus interface and any register bank (video timing, object processor, PIT, interrupt unit).

Parameters:
- AW, 16, address width in bits.
- NREG, 64, number of 16-bit registers in the window; power of two not required.
- BASE, 16'h0400, window base byte address; must be aligned to 2*2^IW.
- WAITS, 1, wait-state cycles between request and strobe/ack; 0 to 15.
- IW (derived), clog2(NREG), register-index width. Not overridable.

Ports:
- sys_clk  in  1  system clock, all state on the rising edge.
- xresetl  in  1  asynchronous active-low reset.
- a  in  AW  byte address; a[0] ignored.
- cs  in  1  internal-device select; must be held high for the whole access.
- rd  in  1  read request, qualified by cs.
- wr  in  1  write request, qualified by cs.
- rdstb  out  NREG  one-hot register read strobe.
- wrstb  out  NREG  one-hot register write strobe.
- ack  out  1  access complete, 1-cycle pulse.
- expl  out  1  external/expansion access, 1-cycle pulse.
- err  out  1  sticky access error.
- err_clr  in  1  clears err.

Behaviour:
- Reset (xresetl low, asynchronous): state=IDLE; rdstb, wrstb, ack and expl are 0; err=0; wait counter=0.
- Address decode:
  - hit = (a[AW-1:IW+1] == BASE[AW-1:IW+1]).
  - idx = a[IW:1].
  - bad = hit & (idx >= NREG).
- IDLE: a request is cs & (rd|wr).
  - On a request, latch a, direction and idx.
  - rd and wr both high: treat as a write and set err.
  - Request that is a hit: go to WAIT with cnt=WAITS, or go straight to STROBE if WAITS=0.
  - Request that is a miss: expl=1 for the next cycle only, no ack, return to IDLE.
- WAIT:
  - cnt decrements every cycle; leave for STROBE when cnt reaches 0.
  - If cs drops, abort to IDLE. No strobe, no ack, err unchanged.
- STROBE (exactly 1 cycle):
  - ack=1.
  - Write: wrstb[idx]=1. Read: rdstb[idx]=1.
  - If bad: no strobe, ack still 1 (the bus never hangs), set err.
  - Next state is IDLE.
- Latency: request sampled at edge N gives ack high in cycle N+1+WAITS. Back-to-back throughput is one access per WAITS+2 cycles.
- A new request is only sampled in IDLE. Requests held across STROBE are re-sampled as a new access; the master must drop cs/rd/wr on ack.
- Strobes are mutually exclusive: at most one bit across rdstb|wrstb is high in any cycle.
- err: set by a dual rd/wr request or a bad index. err_clr clears it. If set and clear happen in the same cycle, set wins.
- Reset asserted mid-access: the access is lost with no strobe and no ack; state returns to IDLE.

Optional Feature:
- Macro IODEC_GEN_ERRLOG_EN.
- Defined:
  - Adds output err_addr [AW-1:0].
  - err_addr captures the latched address of the first error after err was clear. It holds while err=1 and resets to 0.
  - err_clr does not clear err_addr; it re-arms capture.
- Undefined: port and register are absent; err behaviour is unchanged.

Test Plan:
- Defaults (BASE=0x0400, NREG=64, WAITS=1). cs=1, wr=1, a=0x0428 at edge 0 -> wrstb[20] high and ack high in cycle 2 only; all other strobes 0.
- Same config, rd at a=0x0400 -> rdstb[0] high with ack in cycle 2. Then a read at a=0x047E -> rdstb[63].
- Read at a=0x0800 -> expl high in cycle 1 only; no ack, no strobes, err=0.
- NREG=40, write a=0x0460 (idx 48) -> ack in cycle 2, no wrstb, err=1. Then err_clr -> err=0. Both err_clr and a bad access at once -> err stays 1.
- WAITS=4, cs dropped in cycle 3 -> no ack, no strobe, state IDLE. Next request completes normally with ack in cycle 5 after it.
- xresetl low during WAIT -> all outputs 0 immediately. With IODEC_GEN_ERRLOG_EN: a dual rd/wr request at 0x0410 gives err_addr=0x0410, and a second error does not overwrite it.

Source files
------------

// File: rtl/iodec_gen.sv
// iodec_gen: registered I/O window decoder with wait states and error flag.
// Optional IODEC_GEN_ERRLOG_EN adds err_addr capturing the first error address.
module iodec_gen #(
  parameter int            AW    = 16,
  parameter int            NREG  = 64,
  parameter logic [AW-1:0] BASE  = AW'(16'h0400),
  parameter int            WAITS = 1
) (
  input  logic            sys_clk,
  input  logic            xresetl,
  input  logic [AW-1:0]   a,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  output logic [NREG-1:0] rdstb,
  output logic [NREG-1:0] wrstb,
  output logic            ack,
  output logic            expl,
  output logic            err,
  input  logic            err_clr
`ifdef IODEC_GEN_ERRLOG_EN
  ,
  output logic [AW-1:0]   err_addr
`endif
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [IW:0] NREG_W = (IW+1)'(NREG);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STROBE,
    EXPL
  } state_t;

  state_t        state;
  logic [IW-1:0] idx_q;
  logic          wr_q;
  logic [3:0]    cnt;

  logic          req;
  logic          hit;
  logic          dual;
  logic          bad_q;
  logic          err_set;
  logic [NREG-1:0] sel;
  logic          unused_a0;

  assign unused_a0 = a[0];
  assign req  = cs & (rd | wr);
  assign hit  = (a[AW-1:IW+1] == BASE[AW-1:IW+1]);
  assign dual = req & rd & wr;
  assign bad_q = ({1'b0, idx_q} >= NREG_W);
  assign err_set = ((state == IDLE) & dual) |
                   ((state == STROBE) & bad_q);

  // one-hot select of the latched register index
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREG; i++) begin
      sel[i] = (idx_q == IW'(i));
    end
  end

  // access sequencer: idle -> wait -> strobe, or expansion pulse on miss
  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl) begin
      state <= IDLE;
      idx_q <= '0;
      wr_q  <= 1'b0;
      cnt   <= '0;
      rdstb <= '0;
      wrstb <= '0;
      ack   <= 1'b0;
      expl  <= 1'b0;
    end else begin
      rdstb <= '0;
      wrstb <= '0;
      ack   <= 1'b0;
      expl  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q <= a[IW:1];
            wr_q  <= wr;
            if (!hit) begin
              state <= EXPL;
            end else if (WAITS == 0) begin
              state <= STROBE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAITS);
            end
          end
        end
        WAIT: begin
          if (!cs) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt <= 4'd1) begin
            state <= STROBE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          ack <= 1'b1;
          if (!bad_q) begin
            if (wr_q) wrstb <= sel;
            else      rdstb <= sel;
          end
          state <= IDLE;
        end
        EXPL: begin
          expl  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sticky error flag; a new error outranks a clear
  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl)     err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

`ifdef IODEC_GEN_ERRLOG_EN
  logic [AW-1:0] addr_q;

  // full latched address, kept only for error logging
  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl)                       addr_q <= '0;
    else if ((state == IDLE) && req)    addr_q <= a;
  end

  // capture the first error address while capture is armed
  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl) begin
      err_addr <= '0;
    end else if (err_set && (!err || err_clr)) begin
      err_addr <= (state == IDLE) ? a : addr_q;
    end
  end
`endif

endmodule

// File: tb/tb_iodec_gen.sv
// tb_iodec_gen: directed checks for iodec_gen in three configurations.
// Default, NREG=40 and WAITS=4 instances share bus signals, separate selects.
module tb_iodec_gen;

  logic        sys_clk = 1'b0;
  logic        xresetl = 1'b0;
  logic [15:0] a       = '0;
  logic        rd      = 1'b0;
  logic        wr      = 1'b0;
  logic        err_clr = 1'b0;
  logic        cs_d    = 1'b0;
  logic        cs_n    = 1'b0;
  logic        cs_w    = 1'b0;

  logic [63:0] rdstb_d, wrstb_d;
  logic        ack_d, expl_d, err_d;
  logic [39:0] rdstb_n, wrstb_n;
  logic        ack_n, expl_n, err_n;
  logic [63:0] rdstb_w, wrstb_w;
  logic        ack_w, expl_w, err_w;
`ifdef IODEC_GEN_ERRLOG_EN
  logic [15:0] ea_d, ea_n, ea_w;
`endif

  int checks = 0;
  int passed = 0;

  always #5 sys_clk = ~sys_clk;

  iodec_gen u_def (
    .sys_clk(sys_clk), .xresetl(xresetl), .a(a), .cs(cs_d),
    .rd(rd), .wr(wr), .rdstb(rdstb_d), .wrstb(wrstb_d),
    .ack(ack_d), .expl(expl_d), .err(err_d), .err_clr(err_clr)
`ifdef IODEC_GEN_ERRLOG_EN
    , .err_addr(ea_d)
`endif
  );

  iodec_gen #(.NREG(40)) u_n40 (
    .sys_clk(sys_clk), .xresetl(xresetl), .a(a), .cs(cs_n),
    .rd(rd), .wr(wr), .rdstb(rdstb_n), .wrstb(wrstb_n),
    .ack(ack_n), .expl(expl_n), .err(err_n), .err_clr(err_clr)
`ifdef IODEC_GEN_ERRLOG_EN
    , .err_addr(ea_n)
`endif
  );

  iodec_gen #(.WAITS(4)) u_w4 (
    .sys_clk(sys_clk), .xresetl(xresetl), .a(a), .cs(cs_w),
    .rd(rd), .wr(wr), .rdstb(rdstb_w), .wrstb(wrstb_w),
    .ack(ack_w), .expl(expl_w), .err(err_w), .err_clr(err_clr)
`ifdef IODEC_GEN_ERRLOG_EN
    , .err_addr(ea_w)
`endif
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    xresetl = 1'b0;
    tick;
    tick;
    checks++;
    if ({ack_d, expl_d, err_d} !== 3'b000 || rdstb_d !== '0 || wrstb_d !== '0)
      $display("FAIL reset_def: ack/expl/err=%b%b%b rd=%h wr=%h want 0",
               ack_d, expl_d, err_d, rdstb_d, wrstb_d);
    else passed++;
    checks++;
    if ({ack_w, err_w, ack_n, err_n} !== 4'b0000)
      $display("FAIL reset_oth: ack_w/err_w/ack_n/err_n=%b%b%b%b want 0000",
               ack_w, err_w, ack_n, err_n);
    else passed++;
    xresetl = 1'b1;
    tick;
  endtask

  task automatic test_write;
    a = 16'h0428; wr = 1'b1; cs_d = 1'b1;
    tick;
    tick;
    checks++;
    if (ack_d !== 1'b0 || wrstb_d !== '0)
      $display("FAIL wr_early: ack=%b wrstb=%h want 0", ack_d, wrstb_d);
    else passed++;
    tick;
    checks++;
    if (wrstb_d !== (64'd1 << 20) || rdstb_d !== '0 || ack_d !== 1'b1)
      $display("FAIL wr_strobe: wrstb=%h rdstb=%h ack=%b want %h 0 1",
               wrstb_d, rdstb_d, ack_d, 64'd1 << 20);
    else passed++;
    cs_d = 1'b0; wr = 1'b0;
    tick;
    checks++;
    if (ack_d !== 1'b0 || wrstb_d !== '0)
      $display("FAIL wr_pulse: ack=%b wrstb=%h want 0", ack_d, wrstb_d);
    else passed++;
  endtask

  task automatic test_read;
    a = 16'h0400; rd = 1'b1; cs_d = 1'b1;
    tick; tick; tick;
    checks++;
    if (rdstb_d !== 64'd1 || wrstb_d !== '0 || ack_d !== 1'b1)
      $display("FAIL rd_idx0: rdstb=%h wrstb=%h ack=%b want 1 0 1",
               rdstb_d, wrstb_d, ack_d);
    else passed++;
    cs_d = 1'b0; rd = 1'b0;
    tick;
    a = 16'h047E; rd = 1'b1; cs_d = 1'b1;
    tick; tick; tick;
    checks++;
    if (rdstb_d !== 64'h8000_0000_0000_0000 || ack_d !== 1'b1)
      $display("FAIL rd_idx63: rdstb=%h ack=%b want 8000000000000000 1",
               rdstb_d, ack_d);
    else passed++;
    cs_d = 1'b0; rd = 1'b0;
    tick;
  endtask

  task automatic test_expl;
    a = 16'h0800; rd = 1'b1; cs_d = 1'b1;
    tick;
    checks++;
    if (expl_d !== 1'b0)
      $display("FAIL expl_c0: expl=%b want 0", expl_d);
    else passed++;
    tick;
    checks++;
    if (expl_d !== 1'b1 || ack_d !== 1'b0 || rdstb_d !== '0 || wrstb_d !== '0)
      $display("FAIL expl_c1: expl=%b ack=%b rdstb=%h want 1 0 0",
               expl_d, ack_d, rdstb_d);
    else passed++;
    cs_d = 1'b0; rd = 1'b0;
    tick;
    checks++;
    if (expl_d !== 1'b0 || err_d !== 1'b0 || ack_d !== 1'b0)
      $display("FAIL expl_c2: expl=%b err=%b ack=%b want 0 0 0",
               expl_d, err_d, ack_d);
    else passed++;
  endtask

  task automatic test_bad_index;
    a = 16'h044E; wr = 1'b1; cs_n = 1'b1;
    tick; tick; tick;
    checks++;
    if (wrstb_n !== (40'd1 << 39) || ack_n !== 1'b1 || err_n !== 1'b0)
      $display("FAIL n40_idx39: wrstb=%h ack=%b err=%b want 8000000000 1 0",
               wrstb_n, ack_n, err_n);
    else passed++;
    cs_n = 1'b0; wr = 1'b0;
    tick;
    a = 16'h0460; wr = 1'b1; cs_n = 1'b1;
    tick; tick; tick;
    checks++;
    if (ack_n !== 1'b1 || wrstb_n !== '0 || rdstb_n !== '0 || err_n !== 1'b1)
      $display("FAIL n40_bad: ack=%b wrstb=%h err=%b want 1 0 1",
               ack_n, wrstb_n, err_n);
    else passed++;
    cs_n = 1'b0; wr = 1'b0;
    tick;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++;
    if (err_n !== 1'b0)
      $display("FAIL n40_clr: err=%b want 0", err_n);
    else passed++;
    err_clr = 1'b1; a = 16'h0460; wr = 1'b1; cs_n = 1'b1;
    tick; tick; tick;
    checks++;
    if (err_n !== 1'b1 || ack_n !== 1'b1)
      $display("FAIL n40_setwins: err=%b ack=%b want 1 1", err_n, ack_n);
    else passed++;
    cs_n = 1'b0; wr = 1'b0; err_clr = 1'b0;
    tick;
  endtask

  task automatic test_dual;
    a = 16'h0410; rd = 1'b1; wr = 1'b1; cs_d = 1'b1;
    tick;
    checks++;
    if (err_d !== 1'b1)
      $display("FAIL dual_err: err=%b want 1", err_d);
    else passed++;
`ifdef IODEC_GEN_ERRLOG_EN
    checks++;
    if (ea_d !== 16'h0410)
      $display("FAIL dual_eaddr: err_addr=%h want 0410", ea_d);
    else passed++;
`endif
    tick; tick;
    checks++;
    if (wrstb_d !== (64'd1 << 8) || rdstb_d !== '0 || ack_d !== 1'b1)
      $display("FAIL dual_wr: wrstb=%h rdstb=%h ack=%b want %h 0 1",
               wrstb_d, rdstb_d, ack_d, 64'd1 << 8);
    else passed++;
    cs_d = 1'b0; rd = 1'b0; wr = 1'b0;
    tick;
    a = 16'h0420; rd = 1'b1; wr = 1'b1; cs_d = 1'b1;
    tick; tick; tick;
`ifdef IODEC_GEN_ERRLOG_EN
    checks++;
    if (ea_d !== 16'h0410)
      $display("FAIL dual_hold: err_addr=%h want 0410", ea_d);
    else passed++;
`endif
    cs_d = 1'b0; rd = 1'b0; wr = 1'b0;
    tick;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++;
    if (err_d !== 1'b0)
      $display("FAIL dual_clr: err=%b want 0", err_d);
    else passed++;
`ifdef IODEC_GEN_ERRLOG_EN
    checks++;
    if (ea_d !== 16'h0410)
      $display("FAIL clr_keep: err_addr=%h want 0410", ea_d);
    else passed++;
`endif
  endtask

  task automatic test_abort;
    a = 16'h0402; wr = 1'b1; cs_w = 1'b1;
    tick; tick; tick; tick;
    cs_w = 1'b0; wr = 1'b0;
    tick;
    tick;
    checks++;
    if (ack_w !== 1'b0 || wrstb_w !== '0 || err_w !== 1'b0)
      $display("FAIL abort: ack=%b wrstb=%h err=%b want 0 0 0",
               ack_w, wrstb_w, err_w);
    else passed++;
    a = 16'h0404; rd = 1'b1; cs_w = 1'b1;
    tick; tick; tick; tick; tick;
    checks++;
    if (ack_w !== 1'b0)
      $display("FAIL w4_c4: ack=%b want 0", ack_w);
    else passed++;
    tick;
    checks++;
    if (ack_w !== 1'b1 || rdstb_w !== (64'd1 << 2))
      $display("FAIL w4_c5: ack=%b rdstb=%h want 1 %h",
               ack_w, rdstb_w, 64'd1 << 2);
    else passed++;
    cs_w = 1'b0; rd = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    a = 16'h0406; rd = 1'b1; wr = 1'b1; cs_w = 1'b1;
    tick;
    checks++;
    if (err_w !== 1'b1)
      $display("FAIL mid_err: err=%b want 1", err_w);
    else passed++;
    tick;
    #2;
    xresetl = 1'b0;
    #1;
    checks++;
    if ({ack_w, expl_w, err_w} !== 3'b000 || wrstb_w !== '0 || rdstb_w !== '0)
      $display("FAIL mid_rst: ack/expl/err=%b%b%b wrstb=%h want 0",
               ack_w, expl_w, err_w, wrstb_w);
    else passed++;
`ifdef IODEC_GEN_ERRLOG_EN
    checks++;
    if (ea_w !== 16'h0000)
      $display("FAIL mid_eaddr: err_addr=%h want 0000", ea_w);
    else passed++;
`endif
    cs_w = 1'b0; rd = 1'b0; wr = 1'b0;
    #2;
    xresetl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (ack_w !== 1'b0 || wrstb_w !== '0)
        $display("FAIL mid_lost%0d: ack=%b wrstb=%h want 0",
                 i, ack_w, wrstb_w);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_expl;
    test_bad_index;
    test_dual;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
